// File: rtl/fetch_responder_pkg.sv
// Shared fetch-interface types used by Fetch, Decode and the fetch responder.
package tachyon_fetch_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INSN_SIZE  = 4;
  localparam int ADDR_START = 2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:ADDR_START] addr;
    logic [INSN_SIZE*8-1:0]         insn;
    logic                           fault;
  } fetch_rsp_t;

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Synchronous FIFO of fetch responses with a combinational head, push/pop,
// synchronous clear and an occupancy count.
module fetch_rsp_fifo
  import tachyon_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_rsp_t               push_data,
  input  logic                     pop,
  output fetch_rsp_t               head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_rsp_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_pop;

  assign do_pop = pop && (count_reg != '0);

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_responder.sv
// Instruction-fetch responder: range-checks word addresses, reads a 1-cycle
// SRAM and returns ordered responses through a credit-limited FIFO.
module fetch_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:2] MEM_BASE   = '0,
  parameter int                    MEM_WORDS  = 1024,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_WIDTH-1:2]        req_addr,
  input  logic                         flush,
  output logic                         mem_rd_en,
  output logic [$clog2(MEM_WORDS)-1:0] mem_rd_addr,
  input  logic [31:0]                  mem_rd_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ADDR_WIDTH-1:2]        rsp_addr,
  output logic [31:0]                  rsp_insn,
  output logic                         rsp_fault
);

  import tachyon_fetch_pkg::fetch_rsp_t;

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:2] WORDS_W = (ADDR_WIDTH-2)'(MEM_WORDS);

  logic [ADDR_WIDTH-1:2] offset;
  logic                  in_range;
  logic                  accept;
  logic                  inflight_reg;
  logic                  pipe_fault_reg;
  logic [ADDR_WIDTH-1:2] pipe_addr_reg;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        used;
  logic                  pop;
  fetch_rsp_t            push_data;
  fetch_rsp_t            head;

  // Offset form of the range check stays correct even if MEM_BASE+MEM_WORDS wraps.
  assign offset   = req_addr - MEM_BASE;
  assign in_range = (req_addr >= MEM_BASE) && (offset < WORDS_W);

  // Buffered plus in-flight responses must never exceed the FIFO capacity.
  assign used      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
  assign req_ready = !rst && !flush && (used < (CNT_W+1)'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;

  assign mem_rd_en   = accept && in_range;
  assign mem_rd_addr = offset[IDX_W+1:2];

  // accept is already low during flush, which drops the read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg   <= 1'b0;
      pipe_addr_reg  <= '0;
      pipe_fault_reg <= 1'b0;
    end else begin
      inflight_reg <= accept;
      if (accept) begin
        pipe_addr_reg  <= req_addr;
        pipe_fault_reg <= !in_range;
      end
    end
  end

  always_comb begin
    push_data       = '0;
    push_data.addr  = pipe_addr_reg;
    push_data.insn  = pipe_fault_reg ? 32'h0 : mem_rd_data;
    push_data.fault = pipe_fault_reg;
  end

  fetch_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (inflight_reg),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  // FIFO storage is not reset, so the response fields are forced low under reset.
  assign rsp_valid = !rst && (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_addr  = rst ? '0 : head.addr;
  assign rsp_insn  = rst ? 32'h0 : head.insn;
  assign rsp_fault = rst ? 1'b0 : head.fault;

endmodule
